// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, branch condition codes, flag masks, branch FSM states
// and the per-opcode NVZ write-enable decode used by both flag producer and consumer.
package cpu_pkg;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;
  localparam logic [3:0] OpB   = 4'b1100;
  localparam logic [3:0] OpBr  = 4'b1101;

  localparam logic [2:0] CondNeq    = 3'b000;
  localparam logic [2:0] CondEq     = 3'b001;
  localparam logic [2:0] CondGt     = 3'b010;
  localparam logic [2:0] CondLt     = 3'b011;
  localparam logic [2:0] CondGte    = 3'b100;
  localparam logic [2:0] CondLte    = 3'b101;
  localparam logic [2:0] CondOvfl   = 3'b110;
  localparam logic [2:0] CondUncond = 3'b111;

  // Flag masks in {N,V,Z} bit order
  localparam logic [2:0] FlagN = 3'b100;
  localparam logic [2:0] FlagV = 3'b010;
  localparam logic [2:0] FlagZ = 3'b001;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StWait     = 2'b01,
    StRedirect = 2'b10
  } br_state_e;

  function automatic logic [2:0] flag_wr_en(input logic [3:0] opcode);
    logic [2:0] en;
    case (opcode)
      OpAdd, OpSub:               en = FlagN | FlagV | FlagZ;
      OpXor, OpSll, OpSra, OpRor: en = FlagZ;
      default:                    en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Decode/EX/flag inputs and PC-control/statistics outputs of the branch unit.
// master drives the pipeline side, slave is the branch unit itself.
interface branch_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_opcode;
  logic [2:0]       id_cond;
  logic [15:0]      id_pc_plus2;
  logic [8:0]       id_imm9;
  logic [15:0]      id_rs_data;
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [2:0]       NVZ;
  logic             stall;
  logic             flush;
  logic             pc_redirect;
  logic [15:0]      pc_target;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] br_taken_count;

  modport master (
    output id_valid, id_opcode, id_cond, id_pc_plus2, id_imm9, id_rs_data,
    output ex_valid, ex_opcode, NVZ,
    input  stall, flush, pc_redirect, pc_target, br_count, br_taken_count
  );

  modport slave (
    input  id_valid, id_opcode, id_cond, id_pc_plus2, id_imm9, id_rs_data,
    input  ex_valid, ex_opcode, NVZ,
    output stall, flush, pc_redirect, pc_target, br_count, br_taken_count
  );
endinterface

// File: rtl/branch_unit_cond.sv
// Branch condition evaluation: whether the condition holds for the given flags, and which
// flags it depends on (for hazard detection).
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] nvz,
  output logic       taken,
  output logic [2:0] needed
);
  logic n, v, z;
  assign n = nvz[2];
  assign v = nvz[1];
  assign z = nvz[0];

  always_comb begin
    taken  = 1'b0;
    needed = 3'b000;
    case (cond)
      CondNeq:    begin taken = !z;        needed = FlagZ;         end
      CondEq:     begin taken = z;         needed = FlagZ;         end
      CondGt:     begin taken = !z && !n;  needed = FlagN | FlagZ; end
      CondLt:     begin taken = n;         needed = FlagN;         end
      CondGte:    begin taken = z || !n;   needed = FlagN | FlagZ; end
      CondLte:    begin taken = n || z;    needed = FlagN | FlagZ; end
      CondOvfl:   begin taken = v;         needed = FlagV;         end
      default:    begin taken = 1'b1;      needed = 3'b000;        end
    endcase
  end
endmodule

// File: rtl/branch_unit.sv
// Decode-stage branch resolution: flag-hazard stall, target computation, one-cycle
// PC redirect with fetch flush, and saturating branch statistics.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  branch_unit_if.slave bus
);
  br_state_e        state_q;
  logic             redirect_q;
  logic             flush_q;
  logic [15:0]      target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] taken_cnt_q;

  logic        is_branch;
  logic        hazard;
  logic        resolve;
  logic        taken;
  logic [2:0]  needed;
  logic [15:0] target;

  branch_cond u_cond (
    .cond   (bus.id_cond),
    .nvz    (bus.NVZ),
    .taken  (taken),
    .needed (needed)
  );

  assign is_branch = bus.id_valid && (bus.id_opcode == OpB || bus.id_opcode == OpBr);
  assign hazard    = is_branch && bus.ex_valid &&
                     ((needed & flag_wr_en(bus.ex_opcode)) != 3'b000);
  // In StWait the stalled decode instruction is still presented and the flags are now valid
  assign resolve   = (state_q == StIdle && is_branch && !hazard) || state_q == StWait;
  assign target    = (bus.id_opcode == OpBr) ? bus.id_rs_data :
                     bus.id_pc_plus2 + {{6{bus.id_imm9[8]}}, bus.id_imm9, 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      target_q    <= '0;
      cnt_q       <= '0;
      taken_cnt_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      case (state_q)
        StIdle:     if (hazard) state_q <= StWait;
        StWait:     state_q <= StIdle;
        StRedirect: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
      if (resolve) begin
        if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        if (taken) begin
          if (!(&taken_cnt_q)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
          target_q   <= target;
          redirect_q <= 1'b1;
          flush_q    <= 1'b1;
          state_q    <= StRedirect;
        end
      end
    end
  end

  assign bus.stall          = (state_q == StIdle) && hazard;
  assign bus.flush          = flush_q;
  assign bus.pc_redirect    = redirect_q;
  assign bus.pc_target      = target_q;
  assign bus.br_count       = cnt_q;
  assign bus.br_taken_count = taken_cnt_q;
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand sequences for reset
// and saturation, then randomized traffic against a cycle-level reference model.
module tb_branch_unit;
  localparam int unsigned CNT_W  = 4;
  localparam int          MaxCnt = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_unit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        id_valid;
    logic [3:0]  op;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [15:0] rs;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  nvz;
    logic [2:0]  nvz2;
    logic        exp_stall;
    logic        exp_taken;
    logic [15:0] exp_target;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 1'b0; bus.id_opcode = 4'h0; bus.id_cond = 3'b0;
    bus.id_pc_plus2 = 16'h0; bus.id_imm9 = 9'h0; bus.id_rs_data = 16'h0;
    bus.ex_valid = 1'b0; bus.ex_opcode = 4'h0; bus.NVZ = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    do_reset();
    @(negedge clk);
    bus.id_valid = v.id_valid; bus.id_opcode = v.op; bus.id_cond = v.cond;
    bus.id_pc_plus2 = v.pc; bus.id_imm9 = v.imm; bus.id_rs_data = v.rs;
    bus.ex_valid = v.ex_valid; bus.ex_opcode = v.ex_op; bus.NVZ = v.nvz;
    #1 check($sformatf("vec%0d stall", idx), 32'(bus.stall), 32'(v.exp_stall));
    if (v.exp_stall) begin
      @(negedge clk);
      bus.ex_valid = 1'b0; bus.NVZ = v.nvz2;
      #1 check($sformatf("vec%0d wait_stall", idx), 32'(bus.stall), 32'd0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check($sformatf("vec%0d redirect", idx), 32'(bus.pc_redirect), 32'(v.exp_taken));
    check($sformatf("vec%0d flush", idx), 32'(bus.flush), 32'(v.exp_taken));
    if (v.exp_taken) check($sformatf("vec%0d target", idx), 32'(bus.pc_target), 32'(v.exp_target));
    check($sformatf("vec%0d br_count", idx), 32'(bus.br_count), 32'(v.exp_cnt));
    check($sformatf("vec%0d taken_count", idx), 32'(bus.br_taken_count), 32'(v.exp_taken));
    @(negedge clk);
    #1 check($sformatf("vec%0d redirect_one_cycle", idx), 32'(bus.pc_redirect), 32'd0);
  endtask

  // Reference model helpers, written directly from the condition/flag rules
  function automatic bit m_taken(input int c, input bit n, input bit v, input bit z);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_hazard(input int c, input bit exv, input int exop);
    bit need_n, need_v, need_z, wr_all, wr_z;
    need_z = (c == 0 || c == 1 || c == 2 || c == 4 || c == 5);
    need_n = (c == 2 || c == 3 || c == 4 || c == 5);
    need_v = (c == 6);
    wr_all = (exop == 0 || exop == 1);
    wr_z   = wr_all || (exop >= 3 && exop <= 6);
    return exv && ((wr_all && (need_n || need_v)) || (wr_z && need_z));
  endfunction

  function automatic int m_target(input int op, input int pc, input int imm, input int rs);
    int off;
    if (op == 13) return rs;
    off = (imm >= 256) ? imm - 512 : imm;
    return (pc + 2 * off) & 16'hFFFF;
  endfunction

  bit m_waiting, m_redir;
  int m_tgt, m_cnt, m_tcnt;

  initial begin
    vecs[0]  = '{1, 4'hC, 3'd1, 16'h0010, 9'h004, 16'h0, 0, 4'h0, 3'b001, 3'b001, 0, 1, 16'h0018, 1};
    vecs[1]  = '{1, 4'hC, 3'd0, 16'h0010, 9'h004, 16'h0, 0, 4'h0, 3'b001, 3'b001, 0, 0, 16'h0, 1};
    vecs[2]  = '{1, 4'hC, 3'd3, 16'h0100, 9'h010, 16'h0, 1, 4'h0, 3'b000, 3'b100, 1, 1, 16'h0120, 1};
    vecs[3]  = '{1, 4'hC, 3'd6, 16'h0200, 9'h000, 16'h0, 1, 4'h3, 3'b010, 3'b010, 0, 1, 16'h0200, 1};
    vecs[4]  = '{1, 4'hC, 3'd2, 16'h0300, 9'h1F0, 16'h0, 1, 4'h3, 3'b000, 3'b000, 1, 1, 16'h02E0, 1};
    vecs[5]  = '{1, 4'hD, 3'd7, 16'h0000, 9'h000, 16'hFFFE, 1, 4'h0, 3'b000, 3'b000, 0, 1, 16'hFFFE, 1};
    vecs[6]  = '{1, 4'hC, 3'd7, 16'h0000, 9'h1FF, 16'h0, 0, 4'h0, 3'b000, 3'b000, 0, 1, 16'hFFFE, 1};
    vecs[7]  = '{1, 4'hC, 3'd1, 16'h0000, 9'h000, 16'h0, 0, 4'h1, 3'b000, 3'b000, 0, 0, 16'h0, 1};
    vecs[8]  = '{1, 4'hD, 3'd4, 16'h0000, 9'h000, 16'h1234, 1, 4'h4, 3'b100, 3'b101, 1, 1, 16'h1234, 1};
    vecs[9]  = '{1, 4'h0, 3'd7, 16'h0000, 9'h000, 16'h0, 0, 4'h0, 3'b000, 3'b000, 0, 0, 16'h0, 0};
    vecs[10] = '{1, 4'hC, 3'd5, 16'h0040, 9'h0FF, 16'h0, 1, 4'h2, 3'b100, 3'b100, 0, 1, 16'h023E, 1};

    idle_inputs();
    #2 rst = 1'b0;
    #10;
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset redirect", 32'(bus.pc_redirect), 32'd0);
    check("reset flush", 32'(bus.flush), 32'd0);
    check("reset target", 32'(bus.pc_target), 32'd0);
    check("reset br_count", 32'(bus.br_count), 32'd0);
    check("reset taken_count", 32'(bus.br_taken_count), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset while waiting on a hazard aborts the branch
    do_reset();
    @(negedge clk);
    bus.id_valid = 1'b1; bus.id_opcode = 4'hC; bus.id_cond = 3'd3; bus.id_pc_plus2 = 16'h0100;
    bus.ex_valid = 1'b1; bus.ex_opcode = 4'h0; bus.NVZ = 3'b000;
    #1 check("rstwait stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.ex_valid = 1'b0; bus.NVZ = 3'b100;
    rst = 1'b0;
    #1;
    check("rstwait redirect", 32'(bus.pc_redirect), 32'd0);
    check("rstwait br_count", 32'(bus.br_count), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstwait redirect_after", 32'(bus.pc_redirect), 32'd0);
    check("rstwait br_count_after", 32'(bus.br_count), 32'd0);
    check("rstwait taken_after", 32'(bus.br_taken_count), 32'd0);

    // Back-to-back not-taken branches, held past counter saturation
    do_reset();
    @(negedge clk);
    bus.id_valid = 1'b1; bus.id_opcode = 4'hC; bus.id_cond = 3'd1; bus.NVZ = 3'b000;
    repeat (MaxCnt) @(negedge clk);
    #1 check("sat reach", 32'(bus.br_count), 32'(MaxCnt));
    repeat (2) @(negedge clk);
    #1;
    check("sat hold", 32'(bus.br_count), 32'(MaxCnt));
    check("sat taken", 32'(bus.br_taken_count), 32'd0);
    check("sat redirect", 32'(bus.pc_redirect), 32'd0);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit br, exp_stall, hz;
      if (cyc % 80 == 0) begin
        do_reset();
        m_waiting = 0; m_redir = 0; m_tgt = 0; m_cnt = 0; m_tcnt = 0;
      end
      @(negedge clk);
      if (m_waiting) begin
        bus.ex_valid = 1'b0;
        bus.NVZ = 3'($urandom_range(0, 7));
      end else begin
        int sel;
        sel = $urandom_range(0, 3);
        bus.id_valid    = ($urandom_range(0, 3) != 0);
        bus.id_opcode   = (sel == 3) ? 4'($urandom_range(0, 15)) : (sel == 1 ? 4'hD : 4'hC);
        bus.id_cond     = 3'($urandom_range(0, 7));
        bus.id_pc_plus2 = 16'($urandom);
        bus.id_imm9     = 9'($urandom);
        bus.id_rs_data  = 16'($urandom);
        bus.ex_valid    = 1'($urandom);
        bus.ex_opcode   = 4'($urandom_range(0, 7));
        bus.NVZ         = 3'($urandom_range(0, 7));
      end
      #1;
      br = bus.id_valid && (bus.id_opcode == 4'hC || bus.id_opcode == 4'hD);
      hz = br && m_hazard(int'(bus.id_cond), bus.ex_valid, int'(bus.ex_opcode));
      exp_stall = !m_waiting && !m_redir && hz;
      check("rnd stall", 32'(bus.stall), 32'(exp_stall));
      check("rnd redirect", 32'(bus.pc_redirect), 32'(m_redir));
      check("rnd flush", 32'(bus.flush), 32'(m_redir));
      check("rnd target", 32'(bus.pc_target), 32'(m_tgt));
      check("rnd br_count", 32'(bus.br_count), 32'(m_cnt));
      check("rnd taken_count", 32'(bus.br_taken_count), 32'(m_tcnt));
      if (m_redir) begin
        m_redir = 0;
      end else if (m_waiting || (br && !hz)) begin
        m_waiting = 0;
        if (m_cnt < MaxCnt) m_cnt++;
        if (m_taken(int'(bus.id_cond), bus.NVZ[2], bus.NVZ[1], bus.NVZ[0])) begin
          if (m_tcnt < MaxCnt) m_tcnt++;
          m_tgt = m_target(int'(bus.id_opcode), int'(bus.id_pc_plus2), int'(bus.id_imm9),
                           int'(bus.id_rs_data));
          m_redir = 1;
        end
      end else if (hz) begin
        m_waiting = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer side of the NVZ condition-flag interface: resolves B/BR branches in the decode stage against the flag register contents.
- Detects flag hazards against the flag-writing instruction in EX and stalls until the flags are valid.
- Computes the branch target, drives a one-cycle PC redirect plus fetch flush, and keeps branch statistics.
- Sits between decode, the flag register output and the PC/fetch logic.

Parameters:
- CNT_W, 16, width of the branch-statistics counters (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  the decode stage holds a valid instruction.
- id_opcode  in  4  decode opcode; B=4'b1100, BR=4'b1101.
- id_cond  in  3  branch condition code ccc.
- id_pc_plus2  in  16  PC of the decode instruction + 2.
- id_imm9  in  9  signed word offset (B only).
- id_rs_data  in  16  register target (BR only).
- ex_valid  in  1  EX holds a valid instruction.
- ex_opcode  in  4  EX opcode, used for hazard detection.
- NVZ  in  3  flag register output {N,V,Z}.
- stall  out  1  hold PC and IF/ID, insert an EX bubble.
- flush  out  1  squash the IF/ID instruction.
- pc_redirect  out  1  load pc_target into the PC.
- pc_target  out  16  branch target.
- br_count  out  CNT_W  number of resolved branches.
- br_taken_count  out  CNT_W  number of taken branches.

Behaviour:
- Reset (rst=0, async): state=IDLE. stall, flush, pc_redirect, pc_target, br_count and br_taken_count are all 0. A reset in any state aborts it, and no redirect follows.
- Branch: id_valid & (id_opcode==B | id_opcode==BR). Any other opcode has no effect.
- Conditions and the flags each needs:
  - 000 NEQ: Z==0; needs Z.
  - 001 EQ: Z==1; needs Z.
  - 010 GT: Z==0 & N==0; needs N,Z.
  - 011 LT: N==1; needs N.
  - 100 GTE: Z==1 | N==0; needs N,Z.
  - 101 LTE: N==1 | Z==1; needs N,Z.
  - 110 OVFL: V==1; needs V.
  - 111 UNCOND: always taken; needs none.
- Flag writers by ex_opcode:
  - ADD 0000, SUB 0001 write N,V,Z.
  - XOR 0011, SLL 0100, SRA 0101, ROR 0110 write Z only.
- hazard = branch & ex_valid & ((needed flags) & (written flags) != 0).
- FSM, IDLE:
  - Branch with hazard: stall=1 combinationally, next state WAIT.
  - Branch without hazard: resolve this cycle.
- FSM, WAIT:
  - stall=0. Flags have been updated at the previous edge, so resolve unconditionally. EX holds a bubble, so no new hazard arises.
- Resolve:
  - br_count += 1 (saturate at all-ones).
  - If taken: br_taken_count += 1 (saturating). Register pc_target; go to REDIRECT.
  - If not taken: go to IDLE, no outputs.
- FSM, REDIRECT (exactly one cycle):
  - pc_redirect=1, flush=1 (registered outputs).
  - id_valid is ignored (wrong-path instruction). Next state IDLE.
- Target arithmetic, modulo 2^16 (no overflow detection):
  - B: id_pc_plus2 + ({{7{imm9[8]}},imm9} << 1).
  - BR: id_rs_data.
- pc_target holds its last value when not redirecting.
- Latency:
  - No hazard: resolve in cycle N, redirect in N+1.
  - Hazard: stall in N, resolve in N+1, redirect in N+2.
- Back-to-back branches: a not-taken branch followed next cycle by a branch is evaluated normally. A branch in the REDIRECT cycle is discarded and not counted.
- UNCOND never stalls, even behind ADD.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode localparams (ADD, SUB, XOR, SLL, SRA, ROR, B, BR).
  - Condition codes NEQ..UNCOND.
  - FSM state encoding IDLE=2'b00, WAIT=2'b01, REDIRECT=2'b10.
  - Flag-write-enable function (opcode -> 3-bit NVZ enables), shared with the flag register.
- One sub-module, branch_cond: combinational (cond, NVZ) -> {taken, needed_flags[2:0]}.

Test Plan:
- B EQ, imm9=9'h004, id_pc_plus2=16'h0010, NVZ=001, EX idle:
  - resolve cycle: stall=0.
  - next cycle: pc_redirect=flush=1, pc_target=16'h0018.
  - br_count=1, br_taken_count=1.
- B NEQ with NVZ=001 -> not taken: no redirect, br_count=1, br_taken_count=0, state IDLE.
- ADD in EX, B LT in ID, NVZ=000 before the ADD and NVZ=100 written by it:
  - cycle N: stall=1.
  - cycle N+1: resolves taken.
  - cycle N+2: pc_redirect=1.
- XOR in EX with B OVFL in ID -> no stall (V not written by XOR). With cond=GT -> stall 1 cycle.
- BR UNCOND, id_rs_data=16'hFFFE, ADD in EX -> no stall, pc_target=16'hFFFE.
- B UNCOND, imm9=9'h1FF (-1), id_pc_plus2=16'h0000 -> pc_target=16'hFFFE (wrap-around).
- rst=0 asserted during WAIT -> no redirect, counters 0.
- Counter saturation: 2^CNT_W+1 branches -> br_count stays at all-ones.
